// File: rtl/game_pkg.sv
// Shared types and defaults for the game/match scoring pipeline.
package game_pkg;

    localparam int DEF_GAMES_TO_WIN    = 3;
    localparam int DEF_RESTART_TIMEOUT = 8;
    localparam int DEF_MATCH_W         = 4;

    // Encoding of the per-game result coming from game_state.
    typedef logic [1:0] who_t;
    localparam who_t WHO_NONE = 2'b00;
    localparam who_t WHO_P2   = 2'b01;
    localparam who_t WHO_P1   = 2'b10;

    typedef enum logic [1:0] {
        WAIT_CLEAR = 2'd0,
        PLAY       = 2'd1,
        MATCH_DONE = 2'd2
    } match_state_t;

endpackage

// File: rtl/match_tracker_if.sv
// Bus between game_state/host (master) and match_tracker (slave).
interface match_tracker_if
    import game_pkg::*;
#(
    parameter int MATCH_W = DEF_MATCH_W
) ();

    logic               gameover;
    who_t               who;
    logic               match_ack;
    logic               game_restart;
    logic [MATCH_W-1:0] p1_games;
    logic [MATCH_W-1:0] p2_games;
    logic               match_over;
    who_t               match_winner;
    logic               err;

    modport master (
        output gameover, who, match_ack,
        input  game_restart, p1_games, p2_games, match_over, match_winner, err
    );

    modport slave (
        input  gameover, who, match_ack,
        output game_restart, p1_games, p2_games, match_over, match_winner, err
    );

endinterface

// File: rtl/restart_timer.sv
// Counts enabled cycles; flags expiry on the RESTART_TIMEOUT-th enabled
// cycle and wraps back to zero so the flag recurs every RESTART_TIMEOUT cycles.
module restart_timer #(
    parameter int RESTART_TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CW = $clog2(RESTART_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(RESTART_TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    // Expiry is seen in the same cycle the counter sits at its last value,
    // so the owner can register its pulse on that edge.
    assign expire = en && !clr && (count_reg == LAST);

    // Counter: clear has priority, otherwise count enabled cycles and wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            if (count_reg == LAST) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/match_tracker.sv
// Best-of match scorer: tallies game results from game_state, requests game
// restarts, and holds the match result until the host acknowledges it.
module match_tracker
    import game_pkg::*;
#(
    parameter int GAMES_TO_WIN    = DEF_GAMES_TO_WIN,
    parameter int MATCH_W         = DEF_MATCH_W,
    parameter int RESTART_TIMEOUT = DEF_RESTART_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    match_tracker_if.slave  bus
);

    localparam logic [MATCH_W-1:0] GOAL = MATCH_W'(GAMES_TO_WIN);

    match_state_t       state_reg, state_next;
    logic [MATCH_W-1:0] p1_reg, p1_next, p1_inc;
    logic [MATCH_W-1:0] p2_reg, p2_next, p2_inc;
    logic               over_reg, over_next;
    who_t               winner_reg, winner_next;
    logic               restart_reg, restart_next;
    logic               err_reg, err_next;
    logic               timer_en, timer_expire;

    // The timer only runs while waiting for gameover to drop; any low
    // gameover or any other state clears it.
    assign timer_en = (state_reg == WAIT_CLEAR) && bus.gameover;
    assign p1_inc   = p1_reg + 1'b1;
    assign p2_inc   = p2_reg + 1'b1;

    restart_timer #(
        .RESTART_TIMEOUT (RESTART_TIMEOUT)
    ) u_restart_timer (
        .clk    (clk),
        .reset  (reset),
        .en     (timer_en),
        .clr    (!timer_en),
        .expire (timer_expire)
    );

    // State and all output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= WAIT_CLEAR;
            p1_reg      <= '0;
            p2_reg      <= '0;
            over_reg    <= 1'b0;
            winner_reg  <= WHO_NONE;
            restart_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            p1_reg      <= p1_next;
            p2_reg      <= p2_next;
            over_reg    <= over_next;
            winner_reg  <= winner_next;
            restart_reg <= restart_next;
            err_reg     <= err_next;
        end
    end

    // Next-state and next-output decode; restart is a pulse so it defaults low.
    always_comb begin
        state_next   = state_reg;
        p1_next      = p1_reg;
        p2_next      = p2_reg;
        over_next    = over_reg;
        winner_next  = winner_reg;
        restart_next = 1'b0;
        err_next     = err_reg;
        case (state_reg)
            WAIT_CLEAR: begin
                if (!bus.gameover) begin
                    state_next = PLAY;
                end else if (timer_expire) begin
                    restart_next = 1'b1;
                end
            end
            PLAY: begin
                if (bus.gameover) begin
                    if (bus.who == WHO_P1) begin
                        p1_next = p1_inc;
                        if (p1_inc == GOAL) begin
                            state_next  = MATCH_DONE;
                            over_next   = 1'b1;
                            winner_next = WHO_P1;
                        end else begin
                            state_next   = WAIT_CLEAR;
                            restart_next = 1'b1;
                        end
                    end else if (bus.who == WHO_P2) begin
                        p2_next = p2_inc;
                        if (p2_inc == GOAL) begin
                            state_next  = MATCH_DONE;
                            over_next   = 1'b1;
                            winner_next = WHO_P2;
                        end else begin
                            state_next   = WAIT_CLEAR;
                            restart_next = 1'b1;
                        end
                    end else begin
                        // Malformed result: flag it, skip the tally, restart anyway.
                        err_next     = 1'b1;
                        state_next   = WAIT_CLEAR;
                        restart_next = 1'b1;
                    end
                end
            end
            MATCH_DONE: begin
                if (bus.match_ack) begin
                    p1_next      = '0;
                    p2_next      = '0;
                    over_next    = 1'b0;
                    winner_next  = WHO_NONE;
                    restart_next = 1'b1;
                    state_next   = WAIT_CLEAR;
                end
            end
            default: begin
                state_next = WAIT_CLEAR;
            end
        endcase
    end

    assign bus.game_restart = restart_reg;
    assign bus.p1_games     = p1_reg;
    assign bus.p2_games     = p2_reg;
    assign bus.match_over   = over_reg;
    assign bus.match_winner = winner_reg;
    assign bus.err          = err_reg;

endmodule

// File: tb/tb_match_tracker.sv
// Scoreboard bench for match_tracker: stimulus queues the expected snapshot
// and cycle of every restart pulse / match_over change; a monitor compares.
module tb_match_tracker;
    import game_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    match_tracker_if #(.MATCH_W(4)) bus ();

    match_tracker #(
        .GAMES_TO_WIN    (3),
        .MATCH_W         (4),
        .RESTART_TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int         c;
        logic       r;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       ov;
        logic [1:0] w;
        logic       e;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input int c, input logic r, input logic [3:0] p1,
                            input logic [3:0] p2, input logic ov,
                            input logic [1:0] w, input logic e);
        exp_t x;
        x.c = c; x.r = r; x.p1 = p1; x.p2 = p2; x.ov = ov; x.w = w; x.e = e;
        q.push_back(x);
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end else begin
            $display("check %s: %0d ok", name, got);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".game_restart"}, int'(bus.game_restart), 0);
        check({tag, ".p1_games"},     int'(bus.p1_games), 0);
        check({tag, ".p2_games"},     int'(bus.p2_games), 0);
        check({tag, ".match_over"},   int'(bus.match_over), 0);
        check({tag, ".match_winner"}, int'(bus.match_winner), 0);
        check({tag, ".err"},          int'(bus.err), 0);
    endtask

    // One game: gameover high for hi cycles, then low for 4.
    task automatic play_game(input logic [1:0] w, input int hi, input bit ev,
                             input logic r, input logic [3:0] p1, input logic [3:0] p2,
                             input logic ov, input logic [1:0] win, input logic e);
        @(negedge clk);
        bus.gameover = 1'b1;
        bus.who      = w;
        if (ev) push_exp(cyc + 1, r, p1, p2, ov, win, e);
        repeat (hi) @(negedge clk);
        bus.gameover = 1'b0;
        bus.who      = WHO_NONE;
        repeat (4) @(negedge clk);
    endtask

    task automatic ack(input bit ev, input logic e);
        @(negedge clk);
        bus.match_ack = 1'b1;
        if (ev) push_exp(cyc + 1, 1'b1, 4'd0, 4'd0, 1'b0, WHO_NONE, e);
        @(negedge clk);
        bus.match_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: an event is a restart pulse or a change of match_over.
    initial begin
        logic prev_over;
        exp_t x;
        prev_over = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && (bus.game_restart === 1'b1 || bus.match_over !== prev_over)) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_event cyc=%0d: got restart=%0b p1=%0d p2=%0d over=%0b win=%b err=%0b, required no event",
                             cyc, bus.game_restart, bus.p1_games, bus.p2_games,
                             bus.match_over, bus.match_winner, bus.err);
                end else begin
                    x = q.pop_front();
                    if (x.c != cyc || x.r !== bus.game_restart || x.p1 !== bus.p1_games ||
                        x.p2 !== bus.p2_games || x.ov !== bus.match_over ||
                        x.w !== bus.match_winner || x.e !== bus.err) begin
                        n_miss++;
                        $display("FAIL event: got cyc=%0d restart=%0b p1=%0d p2=%0d over=%0b win=%b err=%0b, required cyc=%0d restart=%0b p1=%0d p2=%0d over=%0b win=%b err=%0b",
                                 cyc, bus.game_restart, bus.p1_games, bus.p2_games,
                                 bus.match_over, bus.match_winner, bus.err,
                                 x.c, x.r, x.p1, x.p2, x.ov, x.w, x.e);
                    end else begin
                        $display("event cyc=%0d restart=%0b p1=%0d p2=%0d over=%0b win=%b err=%0b ok",
                                 cyc, bus.game_restart, bus.p1_games, bus.p2_games,
                                 bus.match_over, bus.match_winner, bus.err);
                    end
                end
            end
            prev_over = bus.match_over;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.gameover  = 1'b0;
        bus.who       = WHO_NONE;
        bus.match_ack = 1'b0;
        reset         = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outputs("idle");

        // P1 sweeps 3-0.
        play_game(WHO_P1, 2, 1'b1, 1'b1, 4'd1, 4'd0, 1'b0, WHO_NONE, 1'b0);
        play_game(WHO_P1, 2, 1'b1, 1'b1, 4'd2, 4'd0, 1'b0, WHO_NONE, 1'b0);
        play_game(WHO_P1, 2, 1'b1, 1'b0, 4'd3, 4'd0, 1'b1, WHO_P1, 1'b0);
        // Further results are ignored while the match result is held.
        play_game(WHO_P2, 2, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, WHO_NONE, 1'b0);
        ack(1'b1, 1'b0);
        // Acknowledge outside MATCH_DONE has no effect.
        ack(1'b0, 1'b0);

        // Mixed match P1, P2, P2, P1, P2.
        play_game(WHO_P1, 2, 1'b1, 1'b1, 4'd1, 4'd0, 1'b0, WHO_NONE, 1'b0);
        play_game(WHO_P2, 2, 1'b1, 1'b1, 4'd1, 4'd1, 1'b0, WHO_NONE, 1'b0);
        play_game(WHO_P2, 2, 1'b1, 1'b1, 4'd1, 4'd2, 1'b0, WHO_NONE, 1'b0);
        play_game(WHO_P1, 2, 1'b1, 1'b1, 4'd2, 4'd2, 1'b0, WHO_NONE, 1'b0);
        play_game(WHO_P2, 2, 1'b1, 1'b0, 4'd2, 4'd3, 1'b1, WHO_P2, 1'b0);
        ack(1'b1, 1'b0);

        // gameover held 20 cycles: counted once, re-pulse at +8 and +16.
        @(negedge clk);
        bus.gameover = 1'b1;
        bus.who      = WHO_P1;
        push_exp(cyc + 1,  1'b1, 4'd1, 4'd0, 1'b0, WHO_NONE, 1'b0);
        push_exp(cyc + 9,  1'b1, 4'd1, 4'd0, 1'b0, WHO_NONE, 1'b0);
        push_exp(cyc + 17, 1'b1, 4'd1, 4'd0, 1'b0, WHO_NONE, 1'b0);
        repeat (20) @(negedge clk);
        bus.gameover = 1'b0;
        bus.who      = WHO_NONE;
        repeat (4) @(negedge clk);

        // Invalid who sets sticky err; tallies unchanged.
        play_game(2'b11, 2, 1'b1, 1'b1, 4'd1, 4'd0, 1'b0, WHO_NONE, 1'b1);
        play_game(WHO_P2, 2, 1'b1, 1'b1, 4'd1, 4'd1, 1'b0, WHO_NONE, 1'b1);
        play_game(WHO_P2, 2, 1'b1, 1'b1, 4'd1, 4'd2, 1'b0, WHO_NONE, 1'b1);
        play_game(WHO_P2, 2, 1'b1, 1'b0, 4'd1, 4'd3, 1'b1, WHO_P2, 1'b1);

        // Asynchronous reset while the result is held.
        check("match_over_before_reset", int'(bus.match_over), 1);
        #2 reset = 1'b0;
        #1 check_zero_outputs("async_reset");
        check("queue_drained_at_reset", q.size(), 0);

        // gameover already high at reset release: first pulse after 8 cycles, no count.
        bus.gameover = 1'b1;
        bus.who      = WHO_P1;
        @(negedge clk);
        reset = 1'b1;
        push_exp(cyc + 8, 1'b1, 4'd0, 4'd0, 1'b0, WHO_NONE, 1'b0);
        repeat (10) @(negedge clk);
        bus.gameover = 1'b0;
        bus.who      = WHO_NONE;
        repeat (5) @(negedge clk);

        check("queue_drained_at_end", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/match_tracker.md
# match_tracker

Match-level scoring stage directly downstream of `game_state`. It consumes the per-game `GAMEOVER`/`WHO` result and tallies games won by each side across a best-of match. It issues a one-cycle restart request to start the next game and declares the match winner once a side reaches `GAMES_TO_WIN`. It holds the match result until the host acknowledges it.

## Interface
Parameters:
- `GAMES_TO_WIN`, 3: games a side must win to take the match; legal range 1 to 2^`MATCH_W`-1.
- `MATCH_W`, 4: width of each game tally.
- `RESTART_TIMEOUT`, 8: cycles `gameover` may stay high in WAIT_CLEAR before `game_restart` is re-pulsed; minimum 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `gameover`  in  1  `GAMEOVER` from `game_state`.
- `who`  in  2  `WHO` from `game_state`: 2'b10 = P1 (WINNER side), 2'b01 = P2 (LOSER side).
- `match_ack`  in  1  host acknowledge of a finished match.
- `game_restart`  out  1  one-cycle pulse requesting a game restart.
- `p1_games`  out  `MATCH_W`  games won by P1 in the current match.
- `p2_games`  out  `MATCH_W`  games won by P2 in the current match.
- `match_over`  out  1  high while a match result is held.
- `match_winner`  out  2  winner encoding (same as `who`); 2'b00 when there is no result.
- `err`  out  1  sticky flag: `gameover` was seen with `who` equal to 2'b00 or 2'b11.

## Operation
- All outputs are registered.
- Reset values:
  - `game_restart`=0, `p1_games`=0, `p2_games`=0, `match_over`=0, `match_winner`=2'b00, `err`=0.
  - FSM state = WAIT_CLEAR; timeout counter = 0.
- WAIT_CLEAR:
  - `gameover`=0 -> PLAY; timeout counter cleared.
  - `gameover`=1 -> timeout counter increments.
  - When the counter reaches `RESTART_TIMEOUT`-1: pulse `game_restart`, clear the counter, stay in WAIT_CLEAR.
- PLAY, `gameover`=1 with valid `who`:
  - Increment the matching tally by 1.
  - If the new tally == `GAMES_TO_WIN`:
    - go to MATCH_DONE;
    - set `match_over`=1 and `match_winner`=`who`;
    - no restart pulse.
  - Otherwise: go to WAIT_CLEAR and pulse `game_restart`.
- PLAY, `gameover`=1 with invalid `who`:
  - Set `err`=1; no tally change.
  - Go to WAIT_CLEAR and pulse `game_restart`.
- PLAY, `gameover`=0: hold.
- MATCH_DONE:
  - Hold tallies, `match_over` and `match_winner`; `gameover` is ignored.
  - On `match_ack`=1:
    - clear both tallies; set `match_over`=0 and `match_winner`=2'b00;
    - pulse `game_restart`; go to WAIT_CLEAR.
- `match_ack` is ignored outside MATCH_DONE.
- Tallies never exceed `GAMES_TO_WIN`, so there is no wrap; the increment is `MATCH_W` bits wide.
- `err` clears only on reset.

## Timing
- Latency: `gameover` sampled high at edge k in PLAY -> tally, state, `match_over`/`match_winner` and `game_restart` all valid after edge k.
- `game_restart` is high for exactly one cycle per event and never on two consecutive cycles.
- A game is counted once only. After a counted game the FSM sits in WAIT_CLEAR, so a `gameover` held high is not re-counted until it has been seen low.
- `gameover` already high at reset release: not counted. Re-pulse timing in WAIT_CLEAR:
  - first `game_restart` at the `RESTART_TIMEOUT`-th cycle of high `gameover` (first pulse after reset);
  - then every `RESTART_TIMEOUT` cycles while `gameover` stays high.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously), including an in-flight `game_restart`.
- `match_ack` in the same cycle as entering MATCH_DONE: ignored, because the state is sampled before the update. The host must hold or re-assert it.

## Structure
- Shared package `game_pkg`:
  - `who_t` constants `WHO_NONE`=2'b00, `WHO_P2`=2'b01, `WHO_P1`=2'b10;
  - FSM enum `match_state_t` {WAIT_CLEAR, PLAY, MATCH_DONE};
  - default values of `GAMES_TO_WIN` and `RESTART_TIMEOUT`.
- One sub-module, `restart_timer`:
  - timeout counter with enable and clear inputs;
  - outputs an expiry pulse after `RESTART_TIMEOUT` enabled cycles.
- Tallies, FSM and output registers live in `match_tracker`.

## Test plan
- Reset with `gameover`=0 -> PLAY after 1 cycle; all outputs 0.
- P1 wins 3 games (`gameover`=1 for 2 cycles, `who`=2'b10, then low for 4 cycles, repeated):
  - tally 1 and 2 each produce a single `game_restart` pulse;
  - the third game gives `p1_games`=3, `match_over`=1, `match_winner`=2'b10, no pulse.
- Mixed sequence P1, P2, P2, P1, P2 -> `p1_games`=2, `p2_games`=3, `match_winner`=2'b01 after the 5th `gameover`.
- `gameover` held high 20 cycles after one game with `RESTART_TIMEOUT`=8 -> exactly one counted game and restart pulses at the event plus 8 and 16 cycles later; no re-count.
- `who`=2'b11 with `gameover`=1 -> `err`=1, tallies unchanged, one `game_restart`; `err` persists until reset.
- In MATCH_DONE:
  - `match_ack` pulse -> tallies 0, `match_over`=0, one `game_restart`;
  - reset asserted in MATCH_DONE -> all outputs 0 without a clock edge.
